// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO with standard or first-word-fall-through read, occupancy count, thresholds and sticky errors
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous flush of pointers, count, read data and error flags
//   push, din           write request and data
//   pop                 read request (standard) or consume acknowledge (FWFT)
//   dout, dout_valid    read data and its qualifier
//   full, empty         occupancy extremes
//   almost_full/empty   count >= AF_THRESH / count <= AE_THRESH
//   count               stored words, 0..DEPTH
//   overflow, underflow sticky error flags, cleared by clr or reset
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] dout_r;
    logic                  dv_r;
    logic                  wr_ok, rd_ok;
    assign wr_ok        = push && !full;
    assign rd_ok        = pop && !empty;
    assign empty        = count == '0;
    assign full         = count == CW'(DEPTH);
    assign almost_full  = count >= CW'(AF_THRESH);
    assign almost_empty = count <= CW'(AE_THRESH);
    // In FWFT mode an empty FIFO shows zero rather than a stale entry
    assign dout         = (FWFT != 0) ? (empty ? '0 : mem[rd_ptr]) : dout_r;
    assign dout_valid   = (FWFT != 0) ? !empty : dv_r;
    always_ff @(posedge clk) begin
        if (rst_n && !clr && wr_ok)
            mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout_r    <= '0;
            dv_r      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout_r    <= '0;
            dv_r      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + AW'(1);
            count     <= count + CW'(wr_ok) - CW'(rd_ok);
            // Standard mode: data is registered and zero in cycles without a read
            dout_r    <= (FWFT == 0 && rd_ok) ? mem[rd_ptr] : '0;
            dv_r      <= FWFT == 0 && rd_ok;
            overflow  <= overflow || (push && full);
            underflow <= underflow || (pop && empty);
        end
    end
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: scoreboard bench driving a standard and an FWFT FIFO with identical stimulus
module tb_sync_fifo_fwft;
    logic        clk = 1'b0;
    logic        rst_n, clr, push, pop;
    logic [31:0] din;
    logic [31:0] s_dout, f_dout;
    logic        s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic        f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0]  s_count, f_count;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m[$];
    logic [31:0] exp_s[$];
    logic [31:0] exp_f[$];
    logic        ovf_m = 1'b0;
    logic        udf_m = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_fwft #(.DATA_WIDTH(32), .DEPTH(16), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .din(din), .pop(pop),
        .dout(s_dout), .dout_valid(s_dv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf));

    sync_fifo_fwft #(.DATA_WIDTH(32), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .din(din), .pop(pop),
        .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    // Monitor: standard words arrive the cycle after the pop, FWFT words are compared while being consumed
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_dv) begin
                if (exp_s.size() == 0) chk("s_unexpected_word", s_dout, 32'hDEAD_BEEF);
                else chk("s_dout", s_dout, exp_s.pop_front());
            end else
                chk("s_idle_dout_zero", s_dout, 32'h0);
            if (f_dv && pop && !clr) begin
                if (exp_f.size() == 0) chk("f_unexpected_word", f_dout, 32'hDEAD_BEEF);
                else chk("f_dout", f_dout, exp_f.pop_front());
            end
        end
    end

    task automatic step(input logic p, input logic [31:0] d, input logic q, input logic c);
        logic acc_w;
        push = p; din = d; pop = q; clr = c;
        acc_w = p && m.size() < 16;
        if (c) begin
            m.delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else begin
            if (p && m.size() == 16) ovf_m = 1'b1;
            if (q && m.size() == 0) udf_m = 1'b1;
            if (q && m.size() > 0) begin
                exp_s.push_back(m[0]);
                exp_f.push_back(m[0]);
                void'(m.pop_front());
            end
            if (acc_w) m.push_back(d);
        end
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr = 1'b0;
        chk("s_count", 32'(s_count), 32'(m.size()));
        chk("f_count", 32'(f_count), 32'(m.size()));
        chk("s_empty", 32'(s_empty), 32'(m.size() == 0));
        chk("s_full", 32'(s_full), 32'(m.size() == 16));
        chk("s_overflow", 32'(s_ovf), 32'(ovf_m));
        chk("s_underflow", 32'(s_udf), 32'(udf_m));
        chk("f_overflow", 32'(f_ovf), 32'(ovf_m));
        chk("f_dout_valid", 32'(f_dv), 32'(m.size() != 0));
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(s_count), 0);
        chk("rst_empty", 32'(s_empty), 1);
        chk("rst_almost_empty", 32'(s_ae), 1);
        chk("rst_full", 32'(s_full), 0);
        chk("rst_almost_full", 32'(s_af), 0);
        chk("rst_dout", s_dout, 0);
        chk("rst_dout_valid", 32'(s_dv), 0);
        chk("rst_overflow", 32'(s_ovf), 0);
        chk("rst_underflow", 32'(s_udf), 0);
        chk("rst_f_dout_valid", 32'(f_dv), 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0);

        // Asynchronous reset with five words stored
        for (int i = 1; i <= 5; i++) step(1, 32'(i), 0, 0);
        chk("pre_reset_count", 32'(s_count), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(s_count), 0);
        chk("async_rst_empty", 32'(s_empty), 1);
        chk("async_rst_f_dout_valid", 32'(f_dv), 0);
        chk("async_rst_f_dout", f_dout, 0);
        m.delete(); exp_s.delete(); exp_f.delete();
        ovf_m = 1'b0; udf_m = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0, 0);

        // Fill 0x1..0x10 checking thresholds
        for (int i = 1; i <= 16; i++) begin
            step(1, 32'(i), 0, 0);
            chk("fill_almost_full", 32'(s_af), 32'(i >= 14));
            chk("fill_almost_empty", 32'(s_ae), 32'(i <= 2));
        end
        chk("fill_full", 32'(s_full), 1);
        chk("fill_count", 32'(s_count), 16);
        step(1, 32'h99, 0, 0);
        chk("overflow_set", 32'(s_ovf), 1);
        chk("overflow_count", 32'(s_count), 16);
        for (int i = 1; i <= 16; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("drain_empty", 32'(s_empty), 1);
        chk("overflow_sticky", 32'(s_ovf), 1);

        // Flush with count 9, overflow set, push high
        for (int i = 0; i < 9; i++) step(1, 32'h30 + 32'(i), 0, 0);
        chk("preflush_count", 32'(s_count), 9);
        step(1, 32'hEE, 0, 1);
        chk("flush_count", 32'(s_count), 0);
        chk("flush_empty", 32'(s_empty), 1);
        chk("flush_overflow", 32'(s_ovf), 0);
        step(0, 0, 0, 0);
        chk("flush_no_write", 32'(s_count), 0);

        // Wrap-around
        for (int i = 0; i < 10; i++) step(1, 32'h10 + 32'(i), 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 32'hA0 + 32'(i), 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("wrap_count", 32'(s_count), 0);

        // FWFT visibility
        step(1, 32'h55, 0, 0);
        chk("fwft_dout", f_dout, 32'h55);
        chk("fwft_valid", 32'(f_dv), 1);
        step(0, 0, 1, 0);
        chk("fwft_valid_after_pop", 32'(f_dv), 0);
        step(0, 0, 0, 0);

        // Boundaries
        step(1, 32'h66, 1, 0);
        chk("pp_empty_count", 32'(s_count), 1);
        chk("pp_empty_underflow", 32'(s_udf), 1);
        chk("pp_empty_f_dout", f_dout, 32'h66);
        for (int i = 0; i < 15; i++) step(1, 32'hC0 + 32'(i), 0, 0);
        step(1, 32'h77, 1, 0);
        chk("pp_full_count", 32'(s_count), 15);
        chk("pp_full_overflow", 32'(s_ovf), 1);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        step(1, 32'h88, 1, 0);
        chk("pp_mid_count", 32'(s_count), 7);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("s_pending", 32'(exp_s.size()), 0);
        chk("f_pending", 32'(exp_f.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
